// File: rtl/stream_pkg.sv
// Shared types and helpers for the narrow-stream width converters.
package stream_pkg;

  typedef enum logic {StIdle, StSend} stream_state_e;

  // Beat counter width: at least one bit even when RATIO==1.
  function automatic int unsigned beat_idx_width(input int unsigned ratio);
    int unsigned w;
    w = $clog2(ratio);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_downsizer.sv
// Wide-to-narrow stream converter: one wide word in, RATIO narrow beats out, last beat flagged.
// Define STREAM_DOWNSIZER_MSB_FIRST_EN to emit the most significant slice first.
module stream_downsizer
  import stream_pkg::*;
#(
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned RATIO     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       input_ready,
  input  logic                       input_valid,
  input  logic [OUT_WIDTH*RATIO-1:0] input_data,
  input  logic                       output_ready,
  output logic                       output_valid,
  output logic [OUT_WIDTH-1:0]       output_data,
  output logic                       output_last
);

  localparam int unsigned IdxW = beat_idx_width(RATIO);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(RATIO - 1);

  stream_state_e              state_q;
  logic [IdxW-1:0]            idx_q;
  logic [OUT_WIDTH*RATIO-1:0] hold_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (input_valid) begin
            hold_q  <= input_data;
            idx_q   <= '0;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (output_ready) begin
            if (idx_q == LastIdx) begin
              // Last beat leaves: reload immediately for zero-bubble streaming.
              idx_q <= '0;
              if (input_valid) begin
                hold_q <= input_data;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign output_valid = (state_q == StSend);
  assign output_last  = output_valid && (idx_q == LastIdx);
  assign input_ready  = !reset && ((state_q == StIdle) || (output_last && output_ready));

  always_comb begin
    output_data = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (idx_q == IdxW'(i)) begin
`ifdef STREAM_DOWNSIZER_MSB_FIRST_EN
        output_data = hold_q[(RATIO-1-i)*OUT_WIDTH +: OUT_WIDTH];
`else
        output_data = hold_q[i*OUT_WIDTH +: OUT_WIDTH];
`endif
      end
    end
  end

endmodule
